// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM state encoding,
// PROT bit positions and default bus widths.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_pkg;
  localparam int APB_ADDR_WIDTH = `APB_ADDR_WIDTH;
  localparam int APB_DATA_WIDTH = `APB_DATA_WIDTH;

  localparam int PROT_PRIV_BIT    = 0;
  localparam int PROT_NONSEC_BIT  = 1;
  localparam int PROT_INSTR_BIT   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;
endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles without pready; expired flags the cycle in which the
// count would reach TIMEOUT. TIMEOUT=0 disables the abort entirely.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clear, enable};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // The current wait cycle is the TIMEOUT-th one without pready.
    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && !expired) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: accepts one command on a valid/ready channel, runs a single
// APB transfer and holds the result on a valid/ready response channel.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // Both channels transfer on a cycle where valid && ready at the rising edge;
  // valid never depends combinationally on ready in either direction.
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr,
  output apb_state_e              dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;

  apb_state_e              state_q, state_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_slverr_q, rsp_slverr_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    tmo_clear, tmo_en, tmo_expired;

  assign tmo_clear = (state_q == SETUP);
  assign tmo_en    = (state_q == ACCESS) && !pready;

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pprot_d  = cmd_prot;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          pstrb_d  = cmd_write ? cmd_strb  : '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready takes priority over a timeout landing in the same cycle.
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (tmo_expired) begin
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Handshake outputs come straight from the state register; reset masks cmd_ready.
  assign cmd_ready   = (state_q == IDLE) && !rst;
  assign rsp_valid   = (state_q == RESP);
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: the initial block plays both the command
// source and the APB slave, with hand-computed expectations at each step.
module tb_apb_master;
  import apb_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  apb_state_e  dbg_state;

  int n_vec;
  int n_err;
  int n_setup, n_access, lat;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one command from IDLE and acts as the slave until a response shows.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int ready_at,
                      input logic [31:0] rd, input logic err,
                      output int o_setup, output int o_access, output int o_lat);
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    exp_wd   = wr ? wdata : 32'h0;
    exp_st   = wr ? strb : 4'h0;
    o_setup  = 0;
    o_access = 0;
    o_lat    = 0;
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_psel", psel, 1'b0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    pready    = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        o_lat = cyc;
        break;
      end
      if (psel) begin
        if (penable) o_access++;
        else o_setup++;
        chk("paddr_stable", paddr, addr);
        chk("pwrite_stable", pwrite, wr);
        chk("pwdata_stable", pwdata, exp_wd);
        chk("pstrb_stable", pstrb, exp_st);
        chk("pprot_stable", pprot, prot);
      end
      if (psel && penable && o_access == ready_at) begin
        pready  = 1'b1;
        prdata  = rd;
        pslverr = err;
      end else begin
        pready  = 1'b0;
        prdata  = 32'hBAD0_BAD0;
        pslverr = 1'b1;
      end
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;
    chk("rsp_valid_in_budget", rsp_valid, 1'b1);
    chk("resp_psel_low", psel, 1'b0);
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_ack", rsp_valid, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cmd_strb = 4'h0; cmd_prot = 3'h0; rsp_ready = 1'b0;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    chk("post_rst_state", dbg_state, IDLE);

    // Write, zero wait states
    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 1, 32'h1111_2222, 1'b0,
         n_setup, n_access, lat);
    chk("wr0_setup_cycles", n_setup, 1);
    chk("wr0_access_cycles", n_access, 1);
    chk("wr0_latency", lat, 3);
    chk("wr0_rdata", rsp_rdata, 32'h0);
    chk("wr0_slverr", rsp_slverr, 1'b0);
    chk("wr0_timeout", rsp_timeout, 1'b0);
    ack();

    // Read, three wait states; pslverr=1 while pready=0 must be ignored
    xfer(1'b0, 32'h0000_0024, 32'hFFFF_FFFF, 4'hF, 3'b011, 4, 32'h1234_5678, 1'b0,
         n_setup, n_access, lat);
    chk("rd3_apb_cycles", n_setup + n_access, 5);
    chk("rd3_latency", lat, 6);
    chk("rd3_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd3_slverr_ignored", rsp_slverr, 1'b0);
    chk("rd3_timeout", rsp_timeout, 1'b0);
    ack();

    // Slave error on the completing cycle
    xfer(1'b1, 32'h0000_0030, 32'h0000_00FF, 4'h1, 3'b001, 1, 32'h0, 1'b1,
         n_setup, n_access, lat);
    chk("err_slverr", rsp_slverr, 1'b1);
    chk("err_timeout", rsp_timeout, 1'b0);
    chk("err_rdata", rsp_rdata, 32'h0);
    ack();

    // Timeout with pready held low
    xfer(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'b010, 0, 32'h0, 1'b0,
         n_setup, n_access, lat);
    chk("tmo_access_cycles", n_access, 16);
    chk("tmo_latency", lat, 18);
    chk("tmo_flag", rsp_timeout, 1'b1);
    chk("tmo_rdata", rsp_rdata, 32'h0);
    chk("tmo_slverr", rsp_slverr, 1'b0);
    ack();

    // pready in the 16th ACCESS cycle wins over the timeout
    xfer(1'b0, 32'h0000_0054, 32'h0, 4'h0, 3'b000, 16, 32'hCAFE_F00D, 1'b0,
         n_setup, n_access, lat);
    chk("tmo_edge_access_cycles", n_access, 16);
    chk("tmo_edge_latency", lat, 18);
    chk("tmo_edge_flag", rsp_timeout, 1'b0);
    chk("tmo_edge_rdata", rsp_rdata, 32'hCAFE_F00D);

    // Response backpressure with a command already offered
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0060;
    cmd_wdata = 32'h0BAD_CAFE; cmd_strb = 4'h3; cmd_prot = 3'b100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rdata_stable", rsp_rdata, 32'hCAFE_F00D);
      chk("bp_timeout_stable", rsp_timeout, 1'b0);
      chk("bp_psel", psel, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle_state", dbg_state, IDLE);
    chk("bp_idle_psel", psel, 1'b0);
    xfer(1'b1, 32'h0000_0060, 32'h0BAD_CAFE, 4'h3, 3'b100, 1, 32'h0, 1'b0,
         n_setup, n_access, lat);
    chk("b2b_access_cycles", n_access, 1);
    chk("b2b_latency", lat, 3);
    ack();

    // Reset during an ACCESS wait state
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040;
    cmd_wdata = 32'h0; cmd_strb = 4'h0; cmd_prot = 3'b000; pready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_setup_state", dbg_state, SETUP);
    @(negedge clk);
    chk("mid_access_state", dbg_state, ACCESS);
    chk("mid_access_penable", penable, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_psel", psel, 1'b0);
    chk("mid_rst_penable", penable, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk("mid_rst_paddr", paddr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b000, 2, 32'h5A5A_0001, 1'b0,
         n_setup, n_access, lat);
    chk("post_mid_rst_rdata", rsp_rdata, 32'h5A5A_0001);
    chk("post_mid_rst_latency", lat, 4);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester (master) that converts a simple valid/ready command into a single APB3/APB4 transfer, then returns the result on a valid/ready response channel. It sits between on-chip control logic and the APB bus, opposite the slave side that the testbench slave interface models. It drives `psel`/`penable`/`paddr`/`pwrite`/`pwdata`/`pstrb`/`pprot`, and samples `pready`/`prdata`/`pslverr`. A ready-timeout abort flags transfers to hung slaves.

## Interface
- `ADDR_WIDTH`, default `APB_ADDR_WIDTH` (32): width of the address bus.
- `DATA_WIDTH`, default `APB_DATA_WIDTH` (32): width of the data bus, multiple of 8.
- `TIMEOUT`, default 16: maximum number of ACCESS cycles to wait for `pready`; 0 disables the timeout.

Ports:
- `clk` in 1: sole clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: a command is offered.
- `cmd_ready` out 1: the block accepts the command.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: transfer address.
- `cmd_wdata` in DATA_WIDTH: write data.
- `cmd_strb` in DATA_WIDTH/8: write byte strobes.
- `cmd_prot` in 3: protection attributes.
- `rsp_valid` out 1: a response is held.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_rdata` out DATA_WIDTH: read data; 0 for writes and timeouts.
- `rsp_slverr` out 1: the slave signalled an error.
- `rsp_timeout` out 1: the transfer was aborted on timeout.
- `psel`, `penable`, `pwrite` out 1 each: APB select, enable and direction.
- `paddr` out ADDR_WIDTH, `pwdata` out DATA_WIDTH, `pstrb` out DATA_WIDTH/8, `pprot` out 3: APB address, write data, strobes and protection.
- `prdata` in DATA_WIDTH, `pready` in 1, `pslverr` in 1: APB slave return signals.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS and RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, the block registers addr, write, wdata, strb and prot onto the `p*` outputs, then moves to SETUP.
  - For a read, `pstrb` and `pwdata` are forced to 0.
- **SETUP**
  - `psel`=1, `penable`=0 for exactly one cycle.
  - The FSM always moves to ACCESS next.
- **ACCESS**
  - `psel`=1, `penable`=1.
  - On `pready`=1:
    - `rsp_rdata` captures `prdata` for a read, or 0 for a write.
    - `rsp_slverr` captures `pslverr`, and `rsp_timeout`=0.
    - The FSM moves to RESP.
  - `pslverr` and `prdata` are ignored when `pready`=0.
- **Timeout**
  - A counter clears on entry to ACCESS and increments for each ACCESS cycle with `pready`=0.
  - When the counter reaches TIMEOUT with `pready` still 0, the FSM moves to RESP with `rsp_timeout`=1, `rsp_slverr`=0 and `rsp_rdata`=0.
  - `pready` and timeout arriving in the same cycle resolve as a normal completion (`pready` wins).
- **RESP**
  - `psel`=0, `penable`=0, `rsp_valid`=1; the response fields are held stable.
  - On `rsp_ready`, the FSM returns to IDLE.
- Response stalls are unbounded, and no new command is accepted while in RESP.
- Between transfers, `paddr`, `pwrite` and `pprot` keep their last values; `pwdata` and `pstrb` keep theirs too.
- All `p*` outputs are stable from SETUP through the final ACCESS cycle.
- Exactly one outstanding transfer at a time; there is no pipelining.

## Timing
- **Reset**: while `rst` is high (asynchronously), the block is in IDLE, all outputs are 0, and `cmd_ready`=0.
- `cmd_ready` goes to 1 in the first cycle after `rst` deasserts.
- **Reset mid-transfer**: `psel` and `penable` drop immediately and the transfer is abandoned with no response. The slave sees an aborted transfer; this is acceptable only under a global reset.
- **Latency**, with command accepted at edge N:
  - SETUP at N+1.
  - Earliest ACCESS at N+2.
  - `pready` sampled at edge N+3 gives `rsp_valid` from N+3.
  - Minimum accept-to-accept period is 4 cycles when `rsp_ready` is tied to 1.
- Each `pready`=0 cycle adds 1 cycle of latency.
- A timeout asserts `rsp_valid` after the 2 + TIMEOUT cycles following acceptance.
- `cmd_ready` and `rsp_valid` are decoded directly from the state register; there is no combinational path from `cmd_valid` or `pready` to any output.

## Structure
- **Package `apb_pkg`** holds:
  - `apb_state_e` {IDLE, SETUP, ACCESS, RESP};
  - PROT bit constants (privileged = bit 0, nonsecure = bit 1, instruction = bit 2);
  - the default widths, taken from `definition.sv` macros.
- **Sub-module `apb_timeout_cnt`**:
  - Ports: clear, enable, expired.
  - Width is `$clog2(TIMEOUT+1)`.
  - With TIMEOUT=0, `expired` is tied to 0.

## Test plan
- **Write, zero-wait**: write 0x0000_0010 ← 0xDEAD_BEEF with strb 0xF, slave `pready`=1 in the first ACCESS → exactly one SETUP and one ACCESS cycle, `rsp_valid` at N+3, rdata=0, slverr=0, timeout=0.
- **Read, three wait states**: read 0x0000_0024 with `pready` high on the 4th ACCESS and `prdata`=0x1234_5678 → rsp_rdata=0x1234_5678, `pstrb`=0 throughout, `paddr` stable over all 5 APB cycles.
- **Slave error**: write with `pslverr`=1 while `pready`=1 → rsp_slverr=1. A second case has `pslverr`=1 while `pready`=0, which must be ignored.
- **Timeout**: TIMEOUT=16 with `pready` held at 0 → `psel` drops after 16 ACCESS cycles, rsp_timeout=1, rdata=0. A second case raises `pready` in cycle 16 → normal completion.
- **Response backpressure and back-to-back**: `rsp_ready`=0 for 5 cycles with `cmd_valid` held → `cmd_ready` stays 0 and response fields stay stable. After `rsp_ready`, the next command is accepted in IDLE with no `psel` glitch.
- **Reset mid-ACCESS**: assert `rst` during a wait state → `psel`, `penable` and `rsp_valid` are 0 asynchronously. After release, a fresh read completes normally.
